// File: rtl/tone_osc.sv
// Dual square-wave tone oscillator with shadowed half-period updates and a 2-bit mixer.
// New half-periods are applied only on a half-period boundary, so a frequency change never produces a runt pulse.
module tone_osc #(
  parameter int HALF_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HALF_W-1:0] freq1,
  input  logic [HALF_W-1:0] freq2,
  input  logic              upd,
  input  logic              en1,
  input  logic              en2,
  output logic              sq1,
  output logic              sq2,
  output logic [1:0]        mix,
  output logic [1:0]        pend
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRE_ONE  = PW'(1);
  localparam logic [HALF_W-1:0] ONE    = HALF_W'(1);

  logic [PW-1:0]            pre_cnt_q, pre_cnt_d;
  logic                     tick;
  logic [1:0][HALF_W-1:0]   act_q, act_d;
  logic [1:0][HALF_W-1:0]   cnt_q, cnt_d;
  logic [1:0][HALF_W-1:0]   shd_q, shd_d;
  logic [1:0][HALF_W-1:0]   freq_w;
  logic [1:0]               sq_q, sq_d;
  logic [1:0]               pend_q, pend_d;
  logic [1:0]               clr;

  assign freq_w = {freq2, freq1};
  assign tick   = (pre_cnt_q == PRE_LAST);

  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
    act_d     = act_q;
    cnt_d     = cnt_q;
    sq_d      = sq_q;
    shd_d     = shd_q;
    clr       = '0;
    if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (act_q[i] == '0) begin
          sq_d[i]  = 1'b0;
          cnt_d[i] = '0;
          if (pend_q[i]) begin
            act_d[i] = shd_q[i];
            clr[i]   = 1'b1;
          end
        end else if (cnt_q[i] != act_q[i] - ONE) begin
          cnt_d[i] = cnt_q[i] + ONE;
        end else begin
          cnt_d[i] = '0;
          sq_d[i]  = ~sq_q[i];
          if (pend_q[i]) begin
            act_d[i] = shd_q[i];
            clr[i]   = 1'b1;
            // Loading silence parks the output low rather than leaving it high.
            if (shd_q[i] == '0) sq_d[i] = 1'b0;
          end
        end
      end
    end
    // A capture in the same cycle as a load keeps the channel pending for the newer value.
    if (upd) begin
      shd_d  = freq_w;
      pend_d = 2'b11;
    end else begin
      pend_d = pend_q & ~clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      act_q     <= '0;
      cnt_q     <= '0;
      shd_q     <= '0;
      sq_q      <= '0;
      pend_q    <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      shd_q     <= shd_d;
      sq_q      <= sq_d;
      pend_q    <= pend_d;
    end
  end

  assign sq1  = sq_q[0];
  assign sq2  = sq_q[1];
  assign pend = pend_q;
  assign mix  = {1'b0, sq_q[0] & en1} + {1'b0, sq_q[1] & en2};

endmodule

// File: tb/tb_tone_osc.sv
// Directed bench for tone_osc: a per-cycle vector table plus hand-written boundary sequences,
// with a second instance at PRESCALE=3 for prescaling and asynchronous reset.
module tb_tone_osc;

  logic       clk;
  logic       rst_n, upd, en1, en2;
  logic [7:0] freq1, freq2;
  logic       sq1, sq2;
  logic [1:0] mix, pend;

  logic       rst3_n, upd3;
  logic [7:0] f1_3, f2_3;
  logic       sq1_3, sq2_3;
  logic [1:0] mix3, pend3;

  int checks = 0;
  int errors = 0;

  tone_osc #(.HALF_W(8), .PRESCALE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .freq1(freq1), .freq2(freq2), .upd(upd),
    .en1(en1), .en2(en2), .sq1(sq1), .sq2(sq2), .mix(mix), .pend(pend)
  );

  tone_osc #(.HALF_W(8), .PRESCALE(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .freq1(f1_3), .freq2(f2_3), .upd(upd3),
    .en1(1'b1), .en2(1'b0), .sq1(sq1_3), .sq2(sq2_3), .mix(mix3), .pend(pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       upd;
    logic [7:0] f1;
    logic       en1;
    logic       sq1;
    logic [1:0] mix;
    logic [1:0] pend;
  } vec_t;

  vec_t tv[25];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic u, input logic [7:0] a, input logic [7:0] b,
                       input logic e1, input logic e2);
    @(negedge clk);
    upd = u; freq1 = a; freq2 = b; en1 = e1; en2 = e2;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; upd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic u, input logic [7:0] f, input logic e,
                              input logic s, input logic [1:0] m, input logic [1:0] p);
    vec_t v;
    v.upd = u; v.f1 = f; v.en1 = e; v.sq1 = s; v.mix = m; v.pend = p;
    return v;
  endfunction

  initial begin
    // Run at 4, briefly disable ch1 in the mixer, then retune to 2 one cycle after a toggle.
    tv[0]  = mk(1, 4, 1, 0, 0, 2'b11);
    tv[1]  = mk(0, 0, 1, 0, 0, 2'b00);
    tv[2]  = mk(0, 0, 1, 0, 0, 2'b00);
    tv[3]  = mk(0, 0, 1, 0, 0, 2'b00);
    tv[4]  = mk(0, 0, 1, 0, 0, 2'b00);
    tv[5]  = mk(0, 0, 1, 1, 1, 2'b00);
    tv[6]  = mk(0, 0, 1, 1, 1, 2'b00);
    tv[7]  = mk(0, 0, 0, 1, 0, 2'b00);
    tv[8]  = mk(0, 0, 0, 1, 0, 2'b00);
    tv[9]  = mk(0, 0, 1, 0, 0, 2'b00);
    tv[10] = mk(0, 0, 1, 0, 0, 2'b00);
    tv[11] = mk(0, 0, 1, 0, 0, 2'b00);
    tv[12] = mk(0, 0, 1, 0, 0, 2'b00);
    tv[13] = mk(0, 0, 1, 1, 1, 2'b00);
    tv[14] = mk(1, 2, 1, 1, 1, 2'b11);
    tv[15] = mk(0, 0, 1, 1, 1, 2'b01);
    tv[16] = mk(0, 0, 1, 1, 1, 2'b01);
    tv[17] = mk(0, 0, 1, 0, 0, 2'b00);
    tv[18] = mk(0, 0, 1, 0, 0, 2'b00);
    tv[19] = mk(0, 0, 1, 1, 1, 2'b00);
    tv[20] = mk(0, 0, 1, 1, 1, 2'b00);
    tv[21] = mk(0, 0, 1, 0, 0, 2'b00);
    tv[22] = mk(0, 0, 1, 0, 0, 2'b00);
    tv[23] = mk(0, 0, 1, 1, 1, 2'b00);
    tv[24] = mk(0, 0, 1, 1, 1, 2'b00);

    rst_n = 1'b0; upd = 1'b0; freq1 = '0; freq2 = '0; en1 = 1'b1; en2 = 1'b1;
    rst3_n = 1'b0; upd3 = 1'b0; f1_3 = '0; f2_3 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_sq1", 8'(sq1), 0);
    chk("rst_sq2", 8'(sq2), 0);
    chk("rst_mix", 8'(mix), 0);
    chk("rst_pend", 8'(pend), 0);

    for (int k = 0; k < 25; k++) begin
      drive(tv[k].upd, tv[k].f1, 8'd0, tv[k].en1, 1'b1);
      chk($sformatf("tv%0d_sq1", k), 8'(sq1), 8'(tv[k].sq1));
      chk($sformatf("tv%0d_sq2", k), 8'(sq2), 0);
      chk($sformatf("tv%0d_mix", k), 8'(mix), 8'(tv[k].mix));
      chk($sformatf("tv%0d_pend", k), 8'(pend), 8'(tv[k].pend));
    end

    // Capture landing exactly on a boundary: old shadow (4) loads, 6 applies one half-period later.
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      drive(k == 0 || k == 7 || k == 9, (k == 9) ? 8'd6 : 8'd4, 8'd0, 1'b1, 1'b1);
      if (k == 9)  begin chk("bnd_sq1", 8'(sq1), 0); chk("bnd_pend", 8'(pend), 3); end
      if (k == 12) begin chk("bnd_old_sq1", 8'(sq1), 0); chk("bnd_old_pend", 8'(pend), 1); end
      if (k == 13) begin chk("bnd_old_tog", 8'(sq1), 1); chk("bnd_apply_pend", 8'(pend), 0); end
      if (k == 18) chk("bnd_new_hold", 8'(sq1), 1);
      if (k == 19) chk("bnd_new_tog1", 8'(sq1), 0);
      if (k == 24) chk("bnd_new_hold2", 8'(sq1), 0);
      if (k == 25) chk("bnd_new_tog2", 8'(sq1), 1);
    end

    // Both channels at 3 in phase, then drop en2.
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      drive(k == 0, 8'd3, 8'd3, 1'b1, k < 8);
      if (k == 3)  chk("ph_mix_lo0", 8'(mix), 0);
      if (k == 4)  chk("ph_mix_hi", 8'(mix), 2);
      if (k == 7)  chk("ph_mix_lo", 8'(mix), 0);
      if (k == 10) begin chk("ph_en2off_mix", 8'(mix), 1); chk("ph_en2off_sq2", 8'(sq2), 1); end
    end

    // Silence via freq1=0 at a boundary, then restart at 5.
    do_reset();
    for (int k = 0; k <= 27; k++) begin
      drive(k == 0 || k == 10 || k == 21, (k == 0) ? 8'd4 : (k == 10) ? 8'd0 : 8'd5,
            8'd0, 1'b1, 1'b1);
      if (k == 9)  chk("sil_run_sq1", 8'(sq1), 0);
      if (k == 12) begin chk("sil_pre_sq1", 8'(sq1), 0); chk("sil_pre_pend", 8'(pend), 1); end
      if (k == 13) begin chk("sil_forced_sq1", 8'(sq1), 0); chk("sil_pend", 8'(pend), 0); end
      if (k == 20) chk("sil_hold_sq1", 8'(sq1), 0);
      if (k == 22) chk("rst5_pend", 8'(pend), 0);
      if (k == 26) chk("rst5_pre", 8'(sq1), 0);
      if (k == 27) chk("rst5_tog", 8'(sq1), 1);
    end

    // PRESCALE=3: ticks on every third edge, toggles every 6 clocks; then async reset mid-half-period.
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      rst3_n = 1'b1; upd3 = (e == 1 || e == 22); f1_3 = 8'd2; f2_3 = 8'd0;
      @(posedge clk);
      #1;
      if (e == 8)  chk("p3_pre", 8'(sq1_3), 0);
      if (e == 9)  chk("p3_tog1", 8'(sq1_3), 1);
      if (e == 14) chk("p3_hold", 8'(sq1_3), 1);
      if (e == 15) chk("p3_tog2", 8'(sq1_3), 0);
      if (e == 20) chk("p3_hold2", 8'(sq1_3), 0);
      if (e == 21) chk("p3_tog3", 8'(sq1_3), 1);
      if (e == 22) begin chk("p3_mix_pre", 8'(mix3), 1); chk("p3_pend_pre", 8'(pend3), 3); end
    end
    #1 rst3_n = 1'b0;
    #1;
    chk("p3_arst_sq1", 8'(sq1_3), 0);
    chk("p3_arst_pend", 8'(pend3), 0);
    chk("p3_arst_mix", 8'(mix3), 0);
    @(negedge clk);
    upd3 = 1'b0;
    rst3_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("p3_noshadow_sq1", 8'(sq1_3), 0);
    chk("p3_noshadow_pend", 8'(pend3), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
